// File: rtl/charge_share_arbiter_if.sv
// Signal bundle between one pixel's charge-sharing arbiter and its local/neighbour fabric.
interface charge_share_arbiter_if #(
   parameter int NUM_NB    = 8,
   parameter int CNT_WIDTH = 12
);
   logic                 arbiterEnable;
   logic                 discOutLocal;
   logic [NUM_NB-1:0]    discOutNeighbour;
   logic [NUM_NB-1:0]    nbEnable;
   logic [NUM_NB-1:0]    ackFromNeighbour;
   logic [NUM_NB-1:0]    ackToNeighbour;
   logic                 cntClear;
   logic                 winerAll;
   logic                 busy;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 cntOvf;

   modport slave (
      input  arbiterEnable, discOutLocal, discOutNeighbour, nbEnable,
             ackFromNeighbour, cntClear,
      output ackToNeighbour, winerAll, busy, cnt, cntOvf
   );

   modport master (
      output arbiterEnable, discOutLocal, discOutNeighbour, nbEnable,
             ackFromNeighbour, cntClear,
      input  ackToNeighbour, winerAll, busy, cnt, cntOvf
   );
endinterface

// File: rtl/charge_share_arbiter.sv
// Per-pixel charge-sharing arbiter: a local hit is counted only when no enabled
// neighbour claims the same charge cloud; each arbitrated event is followed by dead time.
module charge_share_arbiter #(
   parameter int                NUM_NB      = 8,
   parameter int                CNT_WIDTH   = 12,
   parameter int                ARB_CYCLES  = 2,
   parameter int                DEAD_CYCLES = 3,
   parameter logic [NUM_NB-1:0] PRIO_LOCAL  = {NUM_NB{1'b1}}
) (
   input logic                   clk,
   input logic                   rst,
   charge_share_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARB  = 2'd1,
      S_HOLD = 2'd2,
      S_DEAD = 2'd3
   } state_t;

   localparam logic [3:0]           ARB_LAST  = 4'(ARB_CYCLES - 1);
   localparam logic [3:0]           DEAD_LAST = 4'(DEAD_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
   localparam logic [NUM_NB-1:0]    NB_ZERO   = {NUM_NB{1'b0}};

   state_t               r_state;
   logic [3:0]           r_phase;
   logic [NUM_NB-1:0]    r_ack;
   logic [NUM_NB-1:0]    r_nb_d;
   logic                 r_local_d;
   logic                 r_win;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 r_ovf;

   state_t               w_state_nxt;
   logic [3:0]           w_phase_nxt;
   logic [NUM_NB-1:0]    w_ack_nxt;
   logic                 w_inc;
   logic                 w_edge;
   logic                 w_win;

   // Local concedes to a neighbour that fired earlier, or that tied and holds priority.
   function automatic logic [NUM_NB-1:0] f_concede(input logic [NUM_NB-1:0] nb_d,
                                                   input logic [NUM_NB-1:0] nb_now,
                                                   input logic [NUM_NB-1:0] nb_en);
      return nb_en & (nb_d | (nb_now & ~PRIO_LOCAL));
   endfunction

   assign w_edge = bus.discOutLocal & ~r_local_d;
   assign w_win  = (&(bus.ackFromNeighbour | ~bus.nbEnable)) & ~(|r_ack);

   // State, phase counter, concession flags and input delay registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_phase   <= 4'd0;
         r_ack     <= NB_ZERO;
         r_nb_d    <= NB_ZERO;
         r_local_d <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_phase   <= w_phase_nxt;
         r_ack     <= w_ack_nxt;
         r_nb_d    <= bus.discOutNeighbour;
         r_local_d <= bus.discOutLocal;
      end
   end

   // Next-state, phase and concession decode; w_inc marks a countable local event.
   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_ack_nxt   = r_ack;
      w_inc       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ack_nxt   = NB_ZERO;
            w_phase_nxt = 4'd0;
            if (!bus.arbiterEnable) begin
               w_inc = w_edge;
            end else if (w_edge) begin
               w_state_nxt = S_ARB;
               w_ack_nxt   = f_concede(r_nb_d, bus.discOutNeighbour, bus.nbEnable);
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ARB: begin
            if (!bus.arbiterEnable || !bus.discOutLocal) begin
               w_state_nxt = S_IDLE;
               w_phase_nxt = 4'd0;
               w_ack_nxt   = NB_ZERO;
            end else if (r_phase == ARB_LAST) begin
               w_state_nxt = S_HOLD;
               w_phase_nxt = 4'd0;
               w_inc       = w_win;
            end else begin
               w_phase_nxt = r_phase + 4'd1;
            end
         end
         S_HOLD: begin
            if (!bus.arbiterEnable) begin
               w_state_nxt = S_IDLE;
               w_ack_nxt   = NB_ZERO;
            end else if (!bus.discOutLocal) begin
               w_state_nxt = S_DEAD;
               w_phase_nxt = 4'd0;
               w_ack_nxt   = NB_ZERO;
            end else begin
               w_state_nxt = S_HOLD;
            end
         end
         S_DEAD: begin
            w_ack_nxt = NB_ZERO;
            if (!bus.arbiterEnable || (r_phase == DEAD_LAST)) begin
               w_state_nxt = S_IDLE;
               w_phase_nxt = 4'd0;
            end else begin
               w_phase_nxt = r_phase + 4'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_phase_nxt = 4'd0;
            w_ack_nxt   = NB_ZERO;
         end
      endcase
   end

   // Win pulse and saturating counter; a clear wins over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_win <= 1'b0;
         r_cnt <= {CNT_WIDTH{1'b0}};
         r_ovf <= 1'b0;
      end else begin
         r_win <= w_inc;
         if (bus.cntClear) begin
            r_cnt <= {CNT_WIDTH{1'b0}};
            r_ovf <= 1'b0;
         end else if (w_inc) begin
            if (r_cnt == CNT_MAX) begin
               r_ovf <= 1'b1;
            end else begin
               r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
         end
      end
   end

   assign bus.ackToNeighbour = r_ack;
   assign bus.winerAll       = r_win;
   assign bus.busy           = (r_state != S_IDLE);
   assign bus.cnt            = r_cnt;
   assign bus.cntOvf         = r_ovf;
endmodule
